// File: rtl/tbi_comma_align_pkg.sv
// Shared definitions for the TBI comma aligner: sync state encoding and
// the two 7-bit comma prefixes of K28.5 (both running disparities).
package tbi_comma_align_pkg;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } sync_state_t;

  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  // True when the first seven bits of a code group form a comma.
  function automatic logic is_comma(input logic [9:0] cg);
    return (cg[9:3] == COMMA_P) || (cg[9:3] == COMMA_N);
  endfunction

endpackage

// File: rtl/tbi_comma_align_comma_scan.sv
// Combinational comma search over the 20-bit window. Candidate k starts
// k bits into the window (bit 19 is the oldest bit on the wire).
module tbi_comma_align_comma_scan
  import tbi_comma_align_pkg::*;
(
  input  logic [19:0] win,
  input  logic [3:0]  locked_offset,
  output logic [9:0]  hit_vec,
  output logic [3:0]  hit_lowest,
  output logic        hit_locked,
  output logic        hit_other
);

  logic [15:0] hit_ext;
  logic [9:0]  locked_mask;

  // Test every candidate offset for a comma prefix.
  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < 10; k++) begin
      hit_vec[k] = is_comma(win[19-k -: 10]);
    end
  end

  // Lowest offset with a comma; scanning downward lets the smallest k win.
  always_comb begin
    hit_lowest = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (hit_vec[k]) hit_lowest = 4'(k);
    end
  end

  // Split hits into the locked offset and everything else.
  always_comb begin
    hit_ext     = {6'b0, hit_vec};
    locked_mask = 10'b1 << locked_offset;
    hit_locked  = hit_ext[locked_offset];
    hit_other   = |(hit_vec & ~locked_mask);
  end

endmodule

// File: rtl/tbi_comma_align.sv
// Receive word aligner: finds the K28.5 comma in the raw SerDes stream,
// locks the bit-slip offset, delivers aligned code groups and tracks sync.
// tbi_out_valid qualifies tbi_out on every cycle it is high; there is no
// back-pressure, so the consumer must take each word while valid is 1.
module tbi_comma_align
  import tbi_comma_align_pkg::*;
#(
  parameter int ACQ_COMMAS    = 3,
  parameter int BAD_LIMIT     = 4,
  parameter int TIMEOUT_WORDS = 1024
) (
  input  logic        tbi_clk,
  input  logic        rst,
  input  logic [9:0]  raw_in,
  input  logic        realign_en,
  output logic [9:0]  tbi_out,
  output logic        tbi_out_valid,
  output logic        sync_status,
  output logic [3:0]  align_offset,
  output logic        comma_det,
  output sync_state_t state_dbg
);

  localparam int TW = $clog2(TIMEOUT_WORDS);
  localparam int AW = $clog2(ACQ_COMMAS + 1);
  localparam int BW = $clog2(BAD_LIMIT + 1);

  localparam logic [AW-1:0] ACQ_TARGET = AW'(ACQ_COMMAS);
  localparam logic [BW-1:0] BAD_MAX    = BW'(BAD_LIMIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_WORDS - 1);

  sync_state_t   state, state_nx;
  logic [9:0]    prev_raw;
  logic [19:0]   win, win_shift;
  logic [9:0]    cand;
  logic [9:0]    hit_vec;
  logic [3:0]    hit_lowest;
  logic          hit_locked, hit_other;
  logic [3:0]    offset_nx;
  logic [AW-1:0] acq_cnt, acq_nx;
  logic [BW-1:0] bad_cnt, bad_nx;
  logic [BW:0]   bad_sum;
  logic [TW-1:0] timer, timer_nx;
  logic          timeout;

  assign win = {prev_raw, raw_in};

  tbi_comma_align_comma_scan u_scan (
    .win           (win),
    .locked_offset (align_offset),
    .hit_vec       (hit_vec),
    .hit_lowest    (hit_lowest),
    .hit_locked    (hit_locked),
    .hit_other     (hit_other)
  );

  // Output mux: shifting left by the offset brings candidate k to the top.
  always_comb begin
    win_shift = win << align_offset;
    cand      = win_shift[19:10];
  end

  // Sync FSM next state; every register holds while realign_en is low.
  always_comb begin
    state_nx  = state;
    offset_nx = align_offset;
    acq_nx    = acq_cnt;
    bad_nx    = bad_cnt;
    timer_nx  = timer;
    bad_sum   = '0;
    timeout   = 1'b0;
    if (realign_en) begin
      unique case (state)
        LOS: begin
          if (|hit_vec) begin
            offset_nx = hit_lowest;
            acq_nx    = AW'(1);
            state_nx  = ACQ;
          end
        end
        ACQ: begin
          if (hit_locked) begin
            acq_nx = acq_cnt + AW'(1);
            if (acq_nx == ACQ_TARGET) begin
              state_nx = SYNC;
              bad_nx   = '0;
              timer_nx = '0;
            end
          end else if (hit_other) begin
            offset_nx = hit_lowest;
            acq_nx    = AW'(1);
          end
        end
        SYNC: begin
          // A locked comma outranks any stray comma in the same window.
          if (hit_locked) begin
            bad_nx   = '0;
            timer_nx = '0;
          end else begin
            timeout  = (timer == TIMER_LAST);
            timer_nx = timeout ? '0 : timer + TW'(1);
            bad_sum  = {1'b0, bad_cnt} + (BW+1)'(hit_other) + (BW+1)'(timeout);
            bad_nx   = (bad_sum >= {1'b0, BAD_MAX}) ? BAD_MAX : bad_sum[BW-1:0];
            if (bad_nx == BAD_MAX) state_nx = LOS;
          end
        end
        default: state_nx = LOS;
      endcase
    end
  end

  // Window, output pipeline, FSM state and counters.
  always_ff @(posedge tbi_clk or posedge rst) begin
    if (rst) begin
      prev_raw     <= '0;
      tbi_out      <= '0;
      comma_det    <= 1'b0;
      state        <= LOS;
      align_offset <= '0;
      acq_cnt      <= '0;
      bad_cnt      <= '0;
      timer        <= '0;
    end else begin
      prev_raw     <= raw_in;
      tbi_out      <= cand;
      comma_det    <= hit_locked;
      state        <= state_nx;
      align_offset <= offset_nx;
      acq_cnt      <= acq_nx;
      bad_cnt      <= bad_nx;
      timer        <= timer_nx;
    end
  end

  assign tbi_out_valid = (state == SYNC);
  assign sync_status   = (state == SYNC);
  assign state_dbg     = state;

endmodule

// File: tb/tb_tbi_comma_align.sv
// Bench for tbi_comma_align: directed scenarios plus a randomized stream,
// all checked against a word-level reference model through a queue.
module tb_tbi_comma_align;
  import tbi_comma_align_pkg::*;

  localparam int ACQ_N   = 3;
  localparam int BAD_N   = 4;
  localparam int TMO_N   = 1024;
  localparam int W       = 19;

  localparam logic [9:0] K_NEG  = 10'b0011111010;
  localparam logic [9:0] K_POS  = 10'b1100000101;
  localparam logic [9:0] D16_2  = 10'b1001000101;
  localparam logic [9:0] FILL   = 10'b0101010101;
  localparam logic [9:0] STRAY  = 10'b0100011111;
  localparam logic [9:0] DUAL_P = 10'b0100111111;
  localparam logic [9:0] DUAL_R = 10'b1000001010;

  logic        tbi_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  raw_in = '0;
  logic        realign_en = 1'b1;
  logic [9:0]  tbi_out;
  logic        tbi_out_valid, sync_status, comma_det;
  logic [3:0]  align_offset;
  sync_state_t state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  bit bits_q[$];
  logic cur_realign = 1'b1;

  // reference model state (0 = LOS, 1 = ACQ, 2 = SYNC)
  int m_state, m_off, m_acq, m_bad, m_timer;
  logic [9:0] m_prev;

  tbi_comma_align #(.ACQ_COMMAS(ACQ_N), .BAD_LIMIT(BAD_N), .TIMEOUT_WORDS(TMO_N)) dut (
    .tbi_clk       (tbi_clk),
    .rst           (rst),
    .raw_in        (raw_in),
    .realign_en    (realign_en),
    .tbi_out       (tbi_out),
    .tbi_out_valid (tbi_out_valid),
    .sync_status   (sync_status),
    .align_offset  (align_offset),
    .comma_det     (comma_det),
    .state_dbg     (state_dbg)
  );

  // clock / watchdog
  always #5 tbi_clk = ~tbi_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached with %0d checks", checks);
    $fatal(1, "watchdog");
  end

  function automatic bit model_comma(input logic [9:0] c);
    logic [6:0] top;
    top = 7'(c >> 3);
    return (top == 7'h1F) || (top == 7'h60);
  endfunction

  task automatic model_reset();
    m_state = 0; m_off = 0; m_acq = 0; m_bad = 0; m_timer = 0; m_prev = '0;
  endtask

  // One word of the reference: scan the two-word window, emit the word at
  // the current offset, then apply the sync rules.
  task automatic model_step(input logic [9:0] w, input logic r);
    logic [19:0] win;
    logic [9:0]  cands[10];
    bit          hits[10];
    int          lowest, inc;
    bit          any_other;
    logic [9:0]  out_w;
    bit          cd;
    win = {m_prev, w};
    lowest = -1;
    any_other = 0;
    for (int k = 0; k < 10; k++) begin
      cands[k] = 10'((win >> (10 - k)) & 20'h003FF);
      hits[k]  = model_comma(cands[k]);
      if (hits[k] && lowest < 0) lowest = k;
      if (hits[k] && k != m_off) any_other = 1;
    end
    out_w = cands[m_off];
    cd    = hits[m_off];
    if (r) begin
      if (m_state == 0) begin
        if (lowest >= 0) begin m_off = lowest; m_acq = 1; m_state = 1; end
      end else if (m_state == 1) begin
        if (hits[m_off]) begin
          m_acq++;
          if (m_acq >= ACQ_N) begin m_state = 2; m_bad = 0; m_timer = 0; end
        end else if (lowest >= 0) begin
          m_off = lowest; m_acq = 1;
        end
      end else begin
        if (hits[m_off]) begin
          m_bad = 0; m_timer = 0;
        end else begin
          inc = any_other ? 1 : 0;
          if (m_timer == TMO_N - 1) begin inc++; m_timer = 0; end
          else m_timer++;
          m_bad = (m_bad + inc > BAD_N) ? BAD_N : m_bad + inc;
          if (m_bad == BAD_N) m_state = 0;
        end
      end
    end
    m_prev = w;
    exp_q.push_back({out_w, m_state == 2, m_state == 2, 4'(m_off), cd, 2'(m_state)});
  endtask

  // driver tasks
  task automatic drive_word(input logic [9:0] w);
    @(negedge tbi_clk);
    raw_in = w;
    realign_en = cur_realign;
    model_step(w, cur_realign);
  endtask

  task automatic add_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  task automatic flush_bits();
    logic [9:0] w;
    while (bits_q.size() >= 10) begin
      for (int i = 9; i >= 0; i--) w[i] = bits_q.pop_front();
      drive_word(w);
    end
  endtask

  task automatic send_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      drive_word(K_NEG);
      drive_word(D16_2);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Let the last driven word be clocked in, then look at the outputs.
  task automatic settle();
    @(posedge tbi_clk);
    #2;
  endtask

  task automatic apply_reset();
    @(negedge tbi_clk);
    rst = 1'b1;
    exp_q.delete();
    bits_q.delete();
    model_reset();
    #1;
    check_eq("rst_tbi_out", 32'(tbi_out), 0);
    check_eq("rst_valid", 32'(tbi_out_valid), 0);
    check_eq("rst_sync", 32'(sync_status), 0);
    check_eq("rst_offset", 32'(align_offset), 0);
    check_eq("rst_comma_det", 32'(comma_det), 0);
    check_eq("rst_state", 32'(state_dbg), 0);
    repeat (2) @(negedge tbi_clk);
    @(posedge tbi_clk);
    #2 rst = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] got, want;
    forever begin
      @(posedge tbi_clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {tbi_out, tbi_out_valid, sync_status, align_offset, comma_det, state_dbg};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got out=%h v=%b s=%b off=%0d cd=%b st=%0d exp out=%h v=%b s=%b off=%0d cd=%b st=%0d",
                   $time, got[18:9], got[8], got[7], got[6:3], got[2], got[1:0],
                   want[18:9], want[8], want[7], want[6:3], want[2], want[1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [9:0] rw;
    int sel;
    model_reset();
    apply_reset();

    // aligned K28.5 / D16.2 stream
    send_pairs(6);
    settle();
    check_eq("t1_sync", 32'(sync_status), 1);
    check_eq("t1_offset", 32'(align_offset), 0);

    // same stream slipped so the code groups sit at offset 7
    apply_reset();
    add_bits(10'b0101010, 7);
    for (int i = 0; i < 6; i++) begin add_bits(K_NEG, 10); add_bits(D16_2, 10); end
    flush_bits();
    settle();
    check_eq("t2_sync", 32'(sync_status), 1);
    check_eq("t2_offset", 32'(align_offset), 7);
    bits_q.delete();

    // stray commas at offset 3 while in sync
    apply_reset();
    send_pairs(4);
    for (int i = 0; i < 3; i++) begin drive_word(FILL); drive_word(STRAY); end
    drive_word(FILL);
    settle();
    check_eq("t3_sync_after3", 32'(sync_status), 1);
    drive_word(STRAY);
    drive_word(FILL);
    drive_word(FILL);
    settle();
    check_eq("t3_sync_after4", 32'(sync_status), 0);
    check_eq("t3_offset_kept", 32'(align_offset), 0);

    // comma timeout, with a refreshing comma near word 1000
    apply_reset();
    send_pairs(4);
    for (int i = 0; i < 999; i++) drive_word(FILL);
    drive_word(K_NEG);
    for (int i = 0; i < 4090; i++) drive_word(FILL);
    settle();
    check_eq("t4_sync_before", 32'(sync_status), 1);
    for (int i = 0; i < 10; i++) drive_word(FILL);
    settle();
    check_eq("t4_sync_after", 32'(sync_status), 0);

    // same-cycle commas at offsets 2 and 9
    apply_reset();
    drive_word(FILL); drive_word(DUAL_P); drive_word(DUAL_R); drive_word(FILL);
    settle();
    check_eq("t5_lock_lowest", 32'(align_offset), 2);
    for (int i = 0; i < 4; i++) begin
      drive_word(DUAL_P); drive_word(DUAL_R); drive_word(FILL);
    end
    settle();
    check_eq("t5_sync", 32'(sync_status), 1);
    for (int i = 0; i < 3; i++) begin drive_word(FILL); drive_word(STRAY); end
    drive_word(FILL); drive_word(FILL);
    settle();
    check_eq("t5_bad_not_counted", 32'(sync_status), 1);
    check_eq("t5_offset", 32'(align_offset), 2);

    // reset in the middle of acquisition
    apply_reset();
    send_pairs(2);
    settle();
    check_eq("t6_in_acq", 32'(state_dbg), 32'(ACQ));
    apply_reset();
    send_pairs(2);
    settle();
    check_eq("t6_no_sync_yet", 32'(sync_status), 0);
    send_pairs(1);
    settle();
    check_eq("t6_sync_fresh", 32'(sync_status), 1);

    // frozen acquisition
    apply_reset();
    cur_realign = 1'b0;
    send_pairs(4);
    settle();
    check_eq("t7_frozen_sync", 32'(sync_status), 0);
    check_eq("t7_frozen_state", 32'(state_dbg), 32'(LOS));
    cur_realign = 1'b1;

    // randomized code stream with slips, noise and freezes
    apply_reset();
    add_bits(10'($urandom_range(0, 1023)), $urandom_range(0, 9));
    for (int i = 0; i < 3000; i++) begin
      cur_realign = ($urandom_range(0, 19) != 0);
      sel = $urandom_range(0, 11);
      if (sel <= 3) rw = K_NEG;
      else if (sel == 4) rw = K_POS;
      else if (sel <= 8) rw = D16_2;
      else if (sel == 9) rw = 10'($urandom_range(0, 1023));
      else if (sel == 10) rw = STRAY;
      else rw = FILL;
      add_bits(rw, 10);
      if ($urandom_range(0, 199) == 0) add_bits(10'($urandom_range(0, 1023)), $urandom_range(1, 9));
      flush_bits();
    end
    cur_realign = 1'b1;
    settle();
    @(posedge tbi_clk);
    #3;
    check_eq("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
